// File: rtl/float_compare_pkg.sv
// float_compare_pkg: opcodes and the canonical quiet NaN shared by the compare pipeline.
package float_compare_pkg;
  typedef enum logic [2:0] {
    FCMP_EQ  = 3'd0,
    FCMP_LT  = 3'd1,
    FCMP_LE  = 3'd2,
    FCMP_MIN = 3'd3,
    FCMP_MAX = 3'd4
  } fcmpOp_e;
  function automatic logic [63:0] canonicalNan(input int expW, input int fracW);
    return (((64'd1 << expW) - 64'd1) << fracW) | (64'd1 << (fracW - 1));
  endfunction
endpackage

// File: rtl/FloatProperties.sv
// FloatProperties: classifies an unsigned {exponent, fraction} field as inf, NaN, zero or denormal.
module FloatProperties #(
  parameter int EXP = 8,
  parameter int FRAC = 23
) (
  input  logic [EXP+FRAC-1:0] magnitude,
  output logic                isInf,
  output logic                isNan,
  output logic                isZero,
  output logic                isDenormal
);
  logic expOnes, expZero, fracZero;
  assign expOnes = &magnitude[EXP+FRAC-1:FRAC];
  assign expZero = ~|magnitude[EXP+FRAC-1:FRAC];
  assign fracZero = ~|magnitude[FRAC-1:0];
  assign isInf = expOnes && fracZero;
  assign isNan = expOnes && !fracZero;
  assign isZero = expZero && fracZero;
  assign isDenormal = expZero && !fracZero;
endmodule

// File: rtl/float_magnitude_cmp.sv
// float_magnitude_cmp: sign-magnitude less-than / equal of two non-NaN floats, with +0 == -0.
module float_magnitude_cmp #(
  parameter int EXP = 8,
  parameter int FRAC = 23,
  localparam int W = 1 + EXP + FRAC
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         aZero,
  input  logic         bZero,
  output logic         lt,
  output logic         eq
);
  logic bothZero, magLt, magGt;
  assign bothZero = aZero && bZero;
  assign magLt = a[W-2:0] < b[W-2:0];
  assign magGt = a[W-2:0] > b[W-2:0];
  assign eq = bothZero || (a == b);
  // Negative operands order inversely to their magnitudes.
  assign lt = !bothZero && ((a[W-1] != b[W-1]) ? a[W-1] : (a[W-1] ? magGt : magLt));
endmodule

// File: rtl/float_compare.sv
// float_compare: two-stage FEQ/FLT/FLE pipeline with valid/ready on both sides.
// Define FLOAT_COMPARE_MINMAX_EN to add FMIN/FMAX; otherwise ops 3/4 behave as reserved.
module float_compare
  import float_compare_pkg::*;
#(
  parameter int EXP = 8,
  parameter int FRAC = 23,
  localparam int W = 1 + EXP + FRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_invalid
);
  logic infA, nanA, zeroA, denA, infB, nanB, zeroB, denB, unusedProps;
  logic s1Valid, s2Valid, s1Adv, inAccept;
  logic [2:0] s1Op;
  logic [W-1:0] s1A, s1B, nxtResult;
  logic s1NanA, s1NanB, s1SnanA, s1SnanB, s1ZeroA, s1ZeroB;
  logic lt, eq, anyNan, anySnan, nxtFlag;
  FloatProperties #(.EXP(EXP), .FRAC(FRAC)) propA (
    .magnitude(a[W-2:0]), .isInf(infA), .isNan(nanA), .isZero(zeroA), .isDenormal(denA)
  );
  FloatProperties #(.EXP(EXP), .FRAC(FRAC)) propB (
    .magnitude(b[W-2:0]), .isInf(infB), .isNan(nanB), .isZero(zeroB), .isDenormal(denB)
  );
  assign unusedProps = ^{infA, infB, denA, denB};
  float_magnitude_cmp #(.EXP(EXP), .FRAC(FRAC)) magCmp (
    .a(s1A), .b(s1B), .aZero(s1ZeroA), .bZero(s1ZeroB), .lt(lt), .eq(eq)
  );
  assign out_valid = s2Valid;
  assign s1Adv = s1Valid && (!s2Valid || out_ready);
  assign in_ready = !s1Valid || s1Adv;
  assign inAccept = in_valid && in_ready;
  assign anyNan = s1NanA || s1NanB;
  assign anySnan = s1SnanA || s1SnanB;
`ifdef FLOAT_COMPARE_MINMAX_EN
  localparam logic [W-1:0] CANON = W'(canonicalNan(EXP, FRAC));
  logic [W-1:0] minVal, maxVal;
  // On equal operands only the zero pair differs; pick by sign so -0 wins min and +0 wins max.
  assign minVal = (s1NanA && s1NanB) ? CANON : s1NanA ? s1B : s1NanB ? s1A :
                  lt ? s1A : eq ? (s1A[W-1] ? s1A : s1B) : s1B;
  assign maxVal = (s1NanA && s1NanB) ? CANON : s1NanA ? s1B : s1NanB ? s1A :
                  lt ? s1B : eq ? (s1A[W-1] ? s1B : s1A) : s1A;
`endif
  always_comb begin
    nxtResult = '0;
    nxtFlag = 1'b0;
    case (s1Op)
      FCMP_EQ: begin nxtResult[0] = !anyNan && eq; nxtFlag = anySnan; end
      FCMP_LT: begin nxtResult[0] = !anyNan && lt; nxtFlag = anyNan; end
      FCMP_LE: begin nxtResult[0] = !anyNan && (lt || eq); nxtFlag = anyNan; end
`ifdef FLOAT_COMPARE_MINMAX_EN
      FCMP_MIN: begin nxtResult = minVal; nxtFlag = anySnan; end
      FCMP_MAX: begin nxtResult = maxVal; nxtFlag = anySnan; end
`endif
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid <= 1'b0;
      s2Valid <= 1'b0;
      s1Op <= '0;
      s1A <= '0;
      s1B <= '0;
      s1NanA <= 1'b0;
      s1NanB <= 1'b0;
      s1SnanA <= 1'b0;
      s1SnanB <= 1'b0;
      s1ZeroA <= 1'b0;
      s1ZeroB <= 1'b0;
      result <= '0;
      flag_invalid <= 1'b0;
    end else begin
      if (inAccept) begin
        s1Op <= op;
        s1A <= a;
        s1B <= b;
        s1NanA <= nanA;
        s1NanB <= nanB;
        s1SnanA <= nanA && !a[FRAC-1];
        s1SnanB <= nanB && !b[FRAC-1];
        s1ZeroA <= zeroA;
        s1ZeroB <= zeroB;
      end
      s1Valid <= inAccept || (s1Valid && !s1Adv);
      if (s1Adv) begin
        result <= nxtResult;
        flag_invalid <= nxtFlag;
      end
      s2Valid <= s1Adv || (s2Valid && !out_ready);
    end
  end
endmodule

// File: tb/tb_float_compare.sv
// tb_float_compare: table-driven vectors through a scoreboard, plus stall, latency and reset sequences.
module tb_float_compare;
  import float_compare_pkg::*;
  localparam int W = 32;
`ifdef FLOAT_COMPARE_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif
  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         flg;
  } vec_t;
  typedef struct packed {
    logic [W-1:0] res;
    logic         flg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, flag_invalid;
  logic [2:0] op;
  logic [W-1:0] a, b, result;
  exp_t sb[$];
  vec_t vecs[$];
  int compared = 0;
  int mismatched = 0;
  int popped = 0;
  bit stallDone;
  exp_t e;

  always #5 clk = ~clk;

  float_compare dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_invalid(flag_invalid)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got %h expected none", result);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("flag_invalid", {31'b0, flag_invalid}, {31'b0, e.flg});
        popped++;
      end
    end
  end

  function automatic logic [W-1:0] mmR(input logic [W-1:0] r);
    return MM ? r : '0;
  endfunction

  function automatic logic mmF(input logic f);
    return MM ? f : 1'b0;
  endfunction

  task automatic add(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] r, input logic f);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.res = r; v.flg = f;
    vecs.push_back(v);
  endtask

  task automatic send(input vec_t v);
    bit ok = 1'b0;
    in_valid = 1'b1; op = v.op; a = v.a; b = v.b;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        sb.push_back('{v.res, v.flg});
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 30 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || !stallDone) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    add(FCMP_LT, 32'h3F800000, 32'h40000000, 32'h1, 1'b0);
    add(FCMP_LT, 32'h40000000, 32'h3F800000, 32'h0, 1'b0);
    add(FCMP_EQ, 32'h80000000, 32'h00000000, 32'h1, 1'b0);
    add(FCMP_LE, 32'h00000001, 32'h00000002, 32'h1, 1'b0);
    add(FCMP_LE, 32'h7FC00000, 32'h3F800000, 32'h0, 1'b1);
    add(FCMP_EQ, 32'h7FC00000, 32'h3F800000, 32'h0, 1'b0);
    add(FCMP_EQ, 32'h7F800001, 32'h3F800000, 32'h0, 1'b1);
    add(FCMP_LT, 32'hBF800000, 32'h3F800000, 32'h1, 1'b0);
    add(FCMP_LT, 32'hC0000000, 32'hBF800000, 32'h1, 1'b0);
    add(FCMP_LT, 32'hBF800000, 32'hC0000000, 32'h0, 1'b0);
    add(FCMP_LE, 32'h3F800000, 32'h3F800000, 32'h1, 1'b0);
    add(FCMP_LT, 32'h00000000, 32'h80000000, 32'h0, 1'b0);
    add(FCMP_LE, 32'h80000000, 32'h00000000, 32'h1, 1'b0);
    add(FCMP_LT, 32'hFF800000, 32'h80000001, 32'h1, 1'b0);
    add(FCMP_LT, 32'h80000002, 32'h80000001, 32'h1, 1'b0);
    add(FCMP_EQ, 32'h7F800000, 32'h7F800000, 32'h1, 1'b0);
    add(FCMP_LT, 32'h3F800000, 32'h7F800001, 32'h0, 1'b1);
    add(3'd5, 32'h3F800000, 32'h40000000, 32'h0, 1'b0);
    add(3'd7, 32'h7F800001, 32'h7F800001, 32'h0, 1'b0);
    add(FCMP_MIN, 32'h7FC00000, 32'hC0000000, mmR(32'hC0000000), 1'b0);
    add(FCMP_MAX, 32'h7F800001, 32'h7FC00000, mmR(32'h7FC00000), mmF(1'b1));
    add(FCMP_MIN, 32'h00000000, 32'h80000000, mmR(32'h80000000), 1'b0);
    add(FCMP_MIN, 32'h80000000, 32'h00000000, mmR(32'h80000000), 1'b0);
    add(FCMP_MAX, 32'h80000000, 32'h00000000, mmR(32'h00000000), 1'b0);
    add(FCMP_MAX, 32'h00000000, 32'h80000000, mmR(32'h00000000), 1'b0);
    add(FCMP_MAX, 32'h3F800000, 32'hC0000000, mmR(32'h3F800000), 1'b0);
    add(FCMP_MIN, 32'h3F800000, 32'hC0000000, mmR(32'hC0000000), 1'b0);
    add(FCMP_MIN, 32'h7F800001, 32'h3F800000, mmR(32'h3F800000), mmF(1'b1));
    add(FCMP_MAX, 32'h7FC00001, 32'hFFC00000, mmR(32'h7FC00000), 1'b0);

    stallDone = 1'b1;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_flag", {31'b0, flag_invalid}, 32'h0);
    check("reset_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;

    send(vecs[0]);
    @(negedge clk);
    check("latency_cycle1_out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    check("latency_cycle2_out_valid", {31'b0, out_valid}, 32'h1);
    @(posedge clk); #1;

    foreach (vecs[i]) send(vecs[i]);
    wait_drain("table_drain");

    @(posedge clk); #1;
    out_ready = 1'b0;
    stallDone = 1'b0;
    base = popped;
    fork
      begin
        for (int i = 0; i < 4; i++) send(vecs[i]);
        stallDone = 1'b1;
      end
    join_none
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", {31'b0, in_ready}, 32'h0);
      check("stall_out_valid", {31'b0, out_valid}, 32'h1);
      check("stall_result_held", result, vecs[0].res);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("stall_drain");
    check("stall_count", popped - base, 4);

    @(posedge clk); #1;
    out_ready = 1'b0;
    send(vecs[0]);
    send(vecs[2]);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("async_reset_result", result, 32'h0);
    check("async_reset_flag", {31'b0, flag_invalid}, 32'h0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;
    send(vecs[4]);
    @(negedge clk);
    check("post_reset_cycle1_out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    check("post_reset_cycle2_out_valid", {31'b0, out_valid}, 32'h1);
    wait_drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/float_compare.md
# float_compare

Pipelined floating-point comparison unit implementing FEQ/FLT/FLE and, when configured, FMIN/FMAX with IEEE-754 semantics. It sits in the execution unit directly downstream of the existing FloatProperties classifier, instantiating one classifier per operand and consuming its isInf/isNan/isZero/isDenormal outputs. Two register stages with valid/ready handshakes on both sides sustain one operation per cycle.

## Interface
- EXP, 8, exponent width
- FRAC, 23, fraction width; operand width W = 1+EXP+FRAC, packed {sign, exponent, fraction}
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  operation accepted when in_valid && in_ready
- op  input  3  0 FEQ, 1 FLT, 2 FLE, 3 FMIN, 4 FMAX, 5–7 reserved
- a  input  W  operand A
- b  input  W  operand B
- out_valid  output  1  result available
- out_ready  input  1  result consumed when out_valid && out_ready
- result  output  W  compare: bit0 = outcome, upper bits 0; min/max: selected value
- flag_invalid  output  1  IEEE invalid-operation exception for this result

## Operation
- Signaling NaN: exp all-ones, frac nonzero, frac MSB 0. Quiet NaN: frac MSB 1.
- Ordering: +0 and −0 compare equal; denormals compared exactly (no flush).
- FEQ: result 1 iff neither NaN and a == b; invalid iff either operand sNaN.
- FLT/FLE: result 0 if either NaN; invalid iff either operand NaN (quiet or signaling).
- FMIN/FMAX: both NaN → canonical NaN (sign 0, exp all-ones, frac MSB only); one NaN → the other operand; min(+0,−0) = −0, max(+0,−0) = +0 in either operand order; invalid iff either operand sNaN.
- Reserved ops: result 0, invalid 0, still occupy a pipeline slot.
- Stage 1 registers op, a, b, and both operands' properties plus sNaN bits. Stage 2 registers result and flag.

## Timing
- Latency: 2 cycles from acceptance to out_valid when not stalled; throughput 1/cycle.
- Stage n advances when its successor is empty or advancing; in_ready = !s1_valid || s1 advancing (combinational path from out_ready is allowed).
- While out_valid && !out_ready, result and flag_invalid hold stable; no operation is lost, duplicated or reordered.
- Two accepted operations fill the pipeline; in_ready then stays low until out_ready.
- Reset (asynchronous, any time): both valid bits 0, result 0, flag_invalid 0, in_ready 1 after release; in-flight operations discarded.
- Values on a, b, op ignored when in_valid is low; outputs don't-care-free: result/flag keep last value when out_valid is 0.

## Configuration
- FLOAT_COMPARE_MINMAX_EN defined: FMIN/FMAX implemented as above.
- Undefined: ops 3 and 4 are treated as reserved (result 0, invalid 0); min/max select logic and canonical-NaN path are not synthesised.

## Structure
- Package float_compare_pkg: op enum (FCMP_EQ, FCMP_LT, FCMP_LE, FCMP_MIN, FCMP_MAX), canonical-NaN constant function parameterised by EXP/FRAC.
- Two FloatProperties instances (one per operand) feed stage 1.
- One new sub-module, float_magnitude_cmp: combinational sign-magnitude less-than/equal of two operands with ±0 equal, used in stage 2.

## Test plan
- FLT a=0x3F800000, b=0x40000000, out_ready=1 → two cycles later result=0x00000001, invalid=0; FLT b,a → 0.
- FEQ a=0x80000000, b=0x00000000 → result=1, invalid=0; FLE 0x00000001 vs 0x00000002 → 1.
- FLE a=0x7FC00000, b=0x3F800000 → 0, invalid=1; FEQ same → 0, invalid=0; FEQ a=0x7F800001 → 0, invalid=1.
- FMIN 0x7FC00000, 0xC0000000 → 0xC0000000, invalid=0; FMAX 0x7F800001, 0x7FC00000 → 0x7FC00000, invalid=1; FMIN 0x00000000, 0x80000000 → 0x80000000 (without macro: 0).
- Stream 4 ops back-to-back, out_ready low 3 cycles → in_ready drops after 2 accepted, result held stable, all 4 results emerge in order after release.
- Assert rst_n low with 2 ops in flight → out_valid=0, result=0 immediately; after release first new op returns after 2 cycles.
